// File: rtl/proc_dbg_pkg.sv
// Shared types for the processor run/step controller: command modes, halt causes
// and controller states.
package proc_dbg_pkg;

  typedef enum logic [1:0] {
    MODE_FREE   = 2'd0,
    MODE_CYCLES = 2'd1,
    MODE_INSTRS = 2'd2,
    MODE_BREAK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_COUNT = 2'd1,
    CAUSE_BREAK = 2'd2,
    CAUSE_USER  = 2'd3
  } cause_e;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRunFree  = 3'd1,
    StRunCyc   = 3'd2,
    StRunInstr = 3'd3,
    StRunBp    = 3'd4
  } state_e;

endpackage

// File: rtl/proc_dbg_trace_buf.sv
// Circular buffer of processor PCs. Each write overwrites the oldest entry; index 0
// reads the newest. Reset clears the write pointer and fill count but not the storage.
module proc_dbg_trace_buf #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] COUNT_FULL = (IDX_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  wr_ptr_q;
  logic [IDX_W:0]    count_q;
  logic [IDX_W-1:0]  rd_ptr;

  // Write pointer and saturating fill count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (wr_en) begin
      wr_ptr_q <= wr_ptr_q + IDX_W'(1);
      if (count_q != COUNT_FULL) begin
        count_q <= count_q + (IDX_W + 1)'(1);
      end
    end
  end

  // Storage is deliberately not reset; only count-qualified entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Newest entry sits just behind the write pointer; wraps because DEPTH is a power of 2.
  assign rd_ptr  = wr_ptr_q - IDX_W'(1) - rd_idx;
  assign rd_data = mem_q[rd_ptr];
  assign count   = count_q;

endmodule

// File: rtl/proc_step_ctrl.sv
// Run/step controller for the 16-bit processor. Gates processor progress and halts
// after N cycles, after N instructions, at a PC breakpoint, or on user request.
// Optional PC trace buffer is built only when DBG_TRACE_EN is defined.
module proc_step_ctrl
  import proc_dbg_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TRACE_DEPTH = 8
) (
  input  logic                             Clock,
  input  logic                             Resetn,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_mode,
  input  logic [CNT_W-1:0]                 cmd_count,
  input  logic [DATA_W-1:0]                bp_addr,
  input  logic                             halt_req,
  input  logic                             proc_done,
  input  logic [DATA_W-1:0]                proc_pc,
  output logic                             proc_clk_en,
  output logic                             proc_run,
  output logic                             busy,
  output logic                             halted,
  output logic [1:0]                       halt_cause,
  output logic [CNT_W-1:0]                 instr_cnt,
  input  logic [$clog2(TRACE_DEPTH)-1:0]   trace_rd_idx,
  output logic [DATA_W-1:0]                trace_rd_data,
  output logic [$clog2(TRACE_DEPTH):0]     trace_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] bp_q;
  logic              halted_q;
  cause_e            cause_q;
  logic [CNT_W-1:0]  instr_cnt_q;
  logic              running;
  logic              done_counted;

  assign running      = (state_q != StIdle);
  assign done_counted = running && proc_done;

  // Run/step FSM with registered halted pulse and halt cause.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bp_q     <= '0;
      halted_q <= 1'b0;
      cause_q  <= CAUSE_NONE;
    end else begin
      halted_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            bp_q    <= bp_addr;
            cnt_q   <= cmd_count;
            cause_q <= CAUSE_NONE;
            unique case (mode_e'(cmd_mode))
              MODE_FREE:   state_q <= StRunFree;
              MODE_BREAK:  state_q <= StRunBp;
              MODE_CYCLES,
              MODE_INSTRS: begin
                // A zero count completes immediately without any enabled cycle.
                if (cmd_count == '0) begin
                  halted_q <= 1'b1;
                  cause_q  <= CAUSE_COUNT;
                end else if (mode_e'(cmd_mode) == MODE_CYCLES) begin
                  state_q <= StRunCyc;
                end else begin
                  state_q <= StRunInstr;
                end
              end
              default: state_q <= StIdle;
            endcase
          end
        end
        default: begin
          // User stop wins over a count expiry or breakpoint hit in the same cycle.
          if (halt_req) begin
            state_q  <= StIdle;
            halted_q <= 1'b1;
            cause_q  <= CAUSE_USER;
          end else begin
            unique case (state_q)
              StRunCyc: begin
                if (cnt_q == CNT_ONE) begin
                  state_q  <= StIdle;
                  halted_q <= 1'b1;
                  cause_q  <= CAUSE_COUNT;
                end else begin
                  cnt_q <= cnt_q - CNT_ONE;
                end
              end
              StRunInstr: begin
                if (proc_done) begin
                  if (cnt_q == CNT_ONE) begin
                    state_q  <= StIdle;
                    halted_q <= 1'b1;
                    cause_q  <= CAUSE_COUNT;
                  end else begin
                    cnt_q <= cnt_q - CNT_ONE;
                  end
                end
              end
              StRunBp: begin
                if (proc_done && (proc_pc == bp_q)) begin
                  state_q  <= StIdle;
                  halted_q <= 1'b1;
                  cause_q  <= CAUSE_BREAK;
                end
              end
              default: state_q <= state_q;
            endcase
          end
        end
      endcase
    end
  end

  // Saturating count of Done pulses seen while the processor is enabled.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      instr_cnt_q <= '0;
    end else if (done_counted && (instr_cnt_q != '1)) begin
      instr_cnt_q <= instr_cnt_q + CNT_ONE;
    end
  end

  assign cmd_ready   = !running;
  assign busy        = running;
  assign proc_clk_en = running;
  assign proc_run    = running;
  assign halted      = halted_q;
  assign halt_cause  = cause_q;
  assign instr_cnt   = instr_cnt_q;

`ifdef DBG_TRACE_EN
  proc_dbg_trace_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace_buf (
    .clk     (Clock),
    .rst_n   (Resetn),
    .wr_en   (done_counted),
    .wr_data (proc_pc),
    .rd_idx  (trace_rd_idx),
    .rd_data (trace_rd_data),
    .count   (trace_count)
  );
`else
  logic unused_trace_idx;
  assign unused_trace_idx = ^trace_rd_idx;
  assign trace_rd_data    = '0;
  assign trace_count      = '0;
`endif

endmodule

// File: tb/tb_proc_step_ctrl.sv
// Directed bench for proc_step_ctrl: count, instruction, breakpoint, free-run,
// zero-count, async reset and (with DBG_TRACE_EN) PC trace readout.
module tb_proc_step_ctrl;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned TRACE_DEPTH = 8;

  logic              Clock = 1'b0;
  logic              Resetn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_mode = 2'd0;
  logic [CNT_W-1:0]  cmd_count = '0;
  logic [DATA_W-1:0] bp_addr = '0;
  logic              halt_req = 1'b0;
  logic              proc_done = 1'b0;
  logic [DATA_W-1:0] proc_pc = '0;
  logic              proc_clk_en;
  logic              proc_run;
  logic              busy;
  logic              halted;
  logic [1:0]        halt_cause;
  logic [CNT_W-1:0]  instr_cnt;
  logic [2:0]        trace_rd_idx = '0;
  logic [DATA_W-1:0] trace_rd_data;
  logic [3:0]        trace_count;

  int n_checks = 0;
  int n_pass   = 0;
  int en_cnt;
  int halt_cyc;

  proc_step_ctrl #(
    .DATA_W      (DATA_W),
    .CNT_W       (CNT_W),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) dut (
    .Clock         (Clock),
    .Resetn        (Resetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_mode      (cmd_mode),
    .cmd_count     (cmd_count),
    .bp_addr       (bp_addr),
    .halt_req      (halt_req),
    .proc_done     (proc_done),
    .proc_pc       (proc_pc),
    .proc_clk_en   (proc_clk_en),
    .proc_run      (proc_run),
    .busy          (busy),
    .halted        (halted),
    .halt_cause    (halt_cause),
    .instr_cnt     (instr_cnt),
    .trace_rd_idx  (trace_rd_idx),
    .trace_rd_data (trace_rd_data),
    .trace_count   (trace_count)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Present one command for a single edge, then scramble the sampled-once inputs.
  task automatic issue(input logic [1:0] mode, input logic [CNT_W-1:0] cnt,
                       input logic [DATA_W-1:0] bp);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_count = cnt;
    bp_addr   = bp;
    step();
    cmd_valid = 1'b0;
    cmd_count = 8'hAA;
    bp_addr   = 16'hFFFF;
  endtask

  // Processor model: Done on every done_every-th enabled cycle, PC = number of prior
  // Dones. Cycle c=0 is the first cycle after the accept edge. Stops when halted seen.
  task automatic run_loop(input int max_cyc, input int done_every, input int halt_at,
                          input int cmd_at, output int en, output int hcyc);
    int dones;
    dones = 0;
    en    = 0;
    hcyc  = -1;
    for (int c = 0; c < max_cyc; c++) begin
      if (halted) begin
        hcyc = c;
        break;
      end
      proc_done = 1'b0;
      halt_req  = (c == halt_at);
      cmd_valid = (c == cmd_at);
      cmd_mode  = 2'd1;
      cmd_count = 8'd2;
      if (c == cmd_at) begin
        check_eq("busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("busy_cause_cleared", {30'd0, halt_cause}, 32'd0);
      end
      if (proc_clk_en) begin
        en++;
        if (done_every > 0 && (en % done_every) == 0) proc_done = 1'b1;
      end
      proc_pc = DATA_W'(dones);
      if (proc_done) dones++;
      step();
    end
    proc_done = 1'b0;
    halt_req  = 1'b0;
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("rst_clk_en", {31'd0, proc_clk_en}, 32'd0);
    check_eq("rst_run", {31'd0, proc_run}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    check_eq("rst_cause", {30'd0, halt_cause}, 32'd0);
    check_eq("rst_instr_cnt", {24'd0, instr_cnt}, 32'd0);
    check_eq("rst_trace_count", {28'd0, trace_count}, 32'd0);
    Resetn = 1'b1;
    step();

    // 1. CYCLES N=8
    issue(2'd1, 8'd8, 16'h0);
    check_eq("cyc_run_mirrors_en", {31'd0, proc_run}, {31'd0, proc_clk_en});
    run_loop(40, 0, -1, -1, en_cnt, halt_cyc);
    check_eq("cyc_enabled", en_cnt, 8);
    check_eq("cyc_halt_cycle", halt_cyc, 8);
    check_eq("cyc_cause", {30'd0, halt_cause}, 32'd1);
    check_eq("cyc_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("cyc_clk_en_off", {31'd0, proc_clk_en}, 32'd0);
    step();
    check_eq("cyc_halted_pulse_end", {31'd0, halted}, 32'd0);
    check_eq("cyc_cause_held", {30'd0, halt_cause}, 32'd1);
    check_eq("cyc_instr_cnt", {24'd0, instr_cnt}, 32'd0);

    // 2. INSTRS N=3, Done every 4 enabled cycles
    issue(2'd2, 8'd3, 16'h0);
    run_loop(60, 4, -1, -1, en_cnt, halt_cyc);
    check_eq("ins_enabled", en_cnt, 12);
    check_eq("ins_halt_cycle", halt_cyc, 12);
    check_eq("ins_instr_cnt", {24'd0, instr_cnt}, 32'd3);
    check_eq("ins_cause", {30'd0, halt_cause}, 32'd1);

    // 3. BREAK at PC 3, Done every 2 enabled cycles, PC 0,1,2,3
    issue(2'd3, 8'd0, 16'h0003);
    run_loop(60, 2, -1, -1, en_cnt, halt_cyc);
    check_eq("bp_enabled", en_cnt, 8);
    check_eq("bp_halt_cycle", halt_cyc, 8);
    check_eq("bp_cause", {30'd0, halt_cause}, 32'd2);
    check_eq("bp_instr_cnt", {24'd0, instr_cnt}, 32'd7);

    // 4. FREE, halt_req at cycle 20, stray command while busy
    issue(2'd0, 8'd0, 16'h0);
    run_loop(60, 0, 20, 5, en_cnt, halt_cyc);
    check_eq("free_enabled", en_cnt, 21);
    check_eq("free_halt_cycle", halt_cyc, 21);
    check_eq("free_cause", {30'd0, halt_cause}, 32'd3);
    repeat (3) step();
    check_eq("free_cmd_not_queued", {31'd0, busy}, 32'd0);
    check_eq("free_clk_en_off", {31'd0, proc_clk_en}, 32'd0);

    // 5a. CYCLES N=0
    issue(2'd1, 8'd0, 16'h0);
    run_loop(10, 0, -1, -1, en_cnt, halt_cyc);
    check_eq("zero_enabled", en_cnt, 0);
    check_eq("zero_halt_cycle", halt_cyc, 0);
    check_eq("zero_cause", {30'd0, halt_cause}, 32'd1);
    step();

    // 5b. INSTRS N=1 with Done and halt_req together
    issue(2'd2, 8'd1, 16'h0);
    run_loop(10, 1, 0, -1, en_cnt, halt_cyc);
    check_eq("prio_enabled", en_cnt, 1);
    check_eq("prio_halt_cycle", halt_cyc, 1);
    check_eq("prio_cause", {30'd0, halt_cause}, 32'd3);
    check_eq("prio_instr_cnt", {24'd0, instr_cnt}, 32'd8);
    step();

    // 6. Asynchronous reset in the middle of a CYCLES run
    issue(2'd1, 8'd20, 16'h0);
    step();
    step();
    check_eq("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    Resetn = 1'b0;
    #1;
    check_eq("arst_clk_en", {31'd0, proc_clk_en}, 32'd0);
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("arst_cause", {30'd0, halt_cause}, 32'd0);
    check_eq("arst_instr_cnt", {24'd0, instr_cnt}, 32'd0);
    #1;
    Resetn = 1'b1;
    step();
    check_eq("arst_no_halted", {31'd0, halted}, 32'd0);

    // 10 instructions with PCs 0..9 for the trace buffer
    issue(2'd2, 8'd10, 16'h0);
    run_loop(40, 1, -1, -1, en_cnt, halt_cyc);
    check_eq("trace_run_enabled", en_cnt, 10);
    check_eq("trace_run_instr_cnt", {24'd0, instr_cnt}, 32'd10);
    trace_rd_idx = 3'd0;
    #1;
`ifdef DBG_TRACE_EN
    check_eq("trace_idx0", {16'd0, trace_rd_data}, 32'd9);
    trace_rd_idx = 3'd7;
    #1;
    check_eq("trace_idx7", {16'd0, trace_rd_data}, 32'd2);
    check_eq("trace_count", {28'd0, trace_count}, 32'd8);
`else
    check_eq("trace_off_data", {16'd0, trace_rd_data}, 32'd0);
    check_eq("trace_off_count", {28'd0, trace_count}, 32'd0);
`endif
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
